mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port data memory.
//
// One requester owns the memory per cycle. A transfer executes on the clock
// edge that ends the owner's gnt cycle: stores via mem_we, loads by
// registering mem_rdata into rdata and pulsing the owner's rvalid for one
// cycle afterwards. An owner still holding req during its gnt cycle is
// treated as making a new request, so a lone requester streams one transfer
// per cycle.
//
// Configuration:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> round-robin between simultaneous
//                                        requests (last_owner register kept)
//                           undefined -> fixed priority, requester 0 wins
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rN_req/we/addr/wdata/addrmode requester N transfer request
//   rN_gnt                        requester N owns memory this cycle
//   rN_rvalid                     one-cycle pulse, rdata holds N's load data
//   rdata                         registered load data (shared)
//   mem_we/addr/wdata/addrmode    data-memory drive
//   mem_rdata                     combinational data-memory read data
module mem_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_req,
  input  logic             r1_req,
  input  logic             r0_we,
  input  logic             r1_we,
  input  logic [WIDTH-1:0] r0_addr,
  input  logic [WIDTH-1:0] r1_addr,
  input  logic [WIDTH-1:0] r0_wdata,
  input  logic [WIDTH-1:0] r1_wdata,
  input  logic [2:0]       r0_addrmode,
  input  logic [2:0]       r1_addrmode,
  output logic             r0_gnt,
  output logic             r1_gnt,
  output logic             r0_rvalid,
  output logic             r1_rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [2:0]       mem_addrmode,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             rvalid0_q, rvalid1_q;
  logic [WIDTH-1:0] rdata_q;
  logic             own0, own1;
  logic             ld0, ld1;
  logic             win1;

  assign own0 = (state_q == S_OWN0);
  assign own1 = (state_q == S_OWN1);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;
  logic last_eff;

  // While someone owns the memory, that owner is the most recent one even
  // though last_owner_q only catches up at the end of this cycle.
  always_comb begin
    last_eff = last_owner_q;
    if (own0) last_eff = 1'b0;
    if (own1) last_eff = 1'b1;
  end

  assign last_owner_d = last_eff;
  // On a tie the requester that did not own last wins.
  assign win1 = r1_req & (~r0_req | ~last_eff);

  always_ff @(posedge clk) begin
    if (rst) last_owner_q <= 1'b1;
    else     last_owner_q <= last_owner_d;
  end
`else
  assign win1 = r1_req & ~r0_req;
`endif

  // Same arbitration from every state: an owner holding req competes anew.
  always_comb begin
    state_d = S_IDLE;
    if (r0_req | r1_req) state_d = win1 ? S_OWN1 : S_OWN0;
  end

  assign ld0 = own0 & r0_req & ~r0_we;
  assign ld1 = own1 & r1_req & ~r1_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rvalid0_q <= ld0;
      rvalid1_q <= ld1;
      if (ld0 | ld1) rdata_q <= mem_rdata;
    end
  end

  assign r0_gnt    = own0;
  assign r1_gnt    = own1;
  assign r0_rvalid = rvalid0_q;
  assign r1_rvalid = rvalid1_q;
  assign rdata     = rdata_q;

  // Requester 1 drives memory only while it owns it; otherwise requester 0's
  // fields sit on the bus with the write suppressed. A reset in an owner
  // cycle kills the store on that same edge.
  assign mem_we       = ~rst & ((own0 & r0_req & r0_we) | (own1 & r1_req & r1_we));
  assign mem_addr     = own1 ? r1_addr     : r0_addr;
  assign mem_wdata    = own1 ? r1_wdata    : r0_wdata;
  assign mem_addrmode = own1 ? r1_addrmode : r0_addrmode;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a small
// word-addressed data-memory model (256 words, addr[9:2]).
module tb_mem_arbiter;

  logic        clk, rst;
  logic        r0_req, r1_req, r0_we, r1_we;
  logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
  logic [2:0]  r0_addrmode, r1_addrmode;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [31:0] rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_addrmode;

  logic [31:0] mem [0:255];
  logic        tb_clr;
  int          n_cmp, n_err;

  mem_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
    .r0_addr(r0_addr), .r1_addr(r1_addr),
    .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_addrmode(r0_addrmode), .r1_addrmode(r1_addrmode),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
    .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .rdata(rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addrmode(mem_addrmode), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] eg, pg;
    n_cmp = 0; n_err = 0;
    tb_clr = 1'b1; rst = 1'b1;
    r0_req = 1'b1; r1_req = 1'b1; r0_we = 1'b0; r1_we = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
    r0_addrmode = 3'b010; r1_addrmode = 3'b010;

    // Reset held two cycles with both requesting.
    for (int c = 0; c < 2; c++) begin
      tick();
      tb_clr = 1'b0;
      chk("rst_gnt",    {30'd0, r1_gnt, r0_gnt}, 32'h0);
      chk("rst_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 32'h0);
      chk("rst_rdata",  rdata, 32'h0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'h0);
    end
    rst = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    tick();

    // Single store from requester 1.
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h40; r1_wdata = 32'hDEADBEEF;
    #1 chk("st_pre_gnt", {31'd0, r1_gnt}, 32'h0);
    tick();
    chk("st_gnt",      {30'd0, r1_gnt, r0_gnt}, 32'h2);
    chk("st_mem_we",   {31'd0, mem_we}, 32'h1);
    chk("st_mem_addr", mem_addr, 32'h40);
    chk("st_mem_wdat", mem_wdata, 32'hDEADBEEF);
    chk("st_mem_mode", {29'd0, mem_addrmode}, 32'h2);
    tick();
    r1_req = 1'b0;
    #1;
    chk("st_mem_word", mem[16], 32'hDEADBEEF);
    chk("st_no_rvld",  {31'd0, r1_rvalid}, 32'h0);
    chk("st_idle_we",  {31'd0, mem_we}, 32'h0);
    tick();

    // Load of the stored word by requester 1.
    r1_req = 1'b1; r1_we = 1'b0;
    tick();
    chk("ld_gnt",     {30'd0, r1_gnt, r0_gnt}, 32'h2);
    chk("ld_mem_we",  {31'd0, mem_we}, 32'h0);
    chk("ld_pre_rv",  {31'd0, r1_rvalid}, 32'h0);
    tick();
    r1_req = 1'b0;
    chk("ld_rvalid",  {30'd0, r1_rvalid, r0_rvalid}, 32'h2);
    chk("ld_rdata",   rdata, 32'hDEADBEEF);
    tick();
    chk("ld_rv_pulse", {31'd0, r1_rvalid}, 32'h0);
    chk("ld_rd_hold",  rdata, 32'hDEADBEEF);
    tick();

    // Back-to-back stores from requester 0, one per cycle.
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h100; r0_wdata = 32'hA0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("b2b_gnt",  {31'd0, r0_gnt}, 32'h1);
      chk("b2b_we",   {31'd0, mem_we}, 32'h1);
      tick();
      if (i < 2) begin
        r0_addr = 32'h104 + 32'(4 * i);
        r0_wdata = 32'hA1 + 32'(i);
      end else begin
        r0_req = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) chk("b2b_mem", mem[64 + i], 32'hA0 + 32'(i));
    chk("b2b_rd_hold", rdata, 32'hDEADBEEF);
    tick();

    // Request dropped before its gnt cycle: OWN0 entered, nothing written.
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h80; r0_wdata = 32'h12345678;
    tick();
    r0_req = 1'b0;
    #1;
    chk("drop_gnt", {31'd0, r0_gnt}, 32'h1);
    chk("drop_we",  {31'd0, mem_we}, 32'h0);
    tick();
    chk("drop_mem", mem[32], 32'h0);
    chk("drop_idle", {30'd0, r1_gnt, r0_gnt}, 32'h0);

    // Reset during a store's gnt cycle suppresses the write.
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h84; r0_wdata = 32'h55;
    tick();
    rst = 1'b1;
    #1 chk("rst_st_we", {31'd0, mem_we}, 32'h0);
    tick();
    chk("rst_st_mem", mem[33], 32'h0);
    rst = 1'b0; r0_req = 1'b0;
    tick();

    // Reset during a load's gnt cycle: no rvalid, rdata stays 0, IDLE next.
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h40;
    tick();
    chk("rst_ld_gnt", {31'd0, r0_gnt}, 32'h1);
    rst = 1'b1;
    tick();
    chk("rst_ld_rv",    {30'd0, r1_rvalid, r0_rvalid}, 32'h0);
    chk("rst_ld_rdata", rdata, 32'h0);
    chk("rst_ld_idle",  {30'd0, r1_gnt, r0_gnt}, 32'h0);
    rst = 1'b0; r0_req = 1'b0;
    tick();

    // Contention: both hold load requests starting straight out of reset.
    rst = 1'b1;
    r0_req = 1'b1; r1_req = 1'b1; r0_we = 1'b0; r1_we = 1'b0;
    r0_addr = 32'h0; r1_addr = 32'h0;
    tick();
    rst = 1'b0;
    #1 chk("cont_idle", {30'd0, r1_gnt, r0_gnt}, 32'h0);
    pg = 2'b00;
    for (int k = 0; k < 5; k++) begin
      tick();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      eg = 2'b01;
`endif
      chk($sformatf("cont_gnt%0d", k), {30'd0, r1_gnt, r0_gnt}, {30'd0, eg});
      chk($sformatf("cont_rv%0d", k), {30'd0, r1_rvalid, r0_rvalid}, {30'd0, pg});
      pg = eg;
    end
    r0_req = 1'b0; r1_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
